// File: rtl/bram_log_slave.sv
// ---------------------------------------------------------------------------
// bram_log_slave
//   Wishbone classic slave that backs the ADC logging block RAM. The logging
//   master writes 32-bit words with byte-lane enables; the CPU side reads them
//   back. The block counts how many non-empty writes were acknowledged and
//   flags when the store is full.
//
// Ports
//   wb_clk_i    in   1         wishbone clock (sole clock)
//   reset_n     in   1         asynchronous active-low reset
//   wb_cyc_i    in   1         bus cycle valid
//   wb_stb_i    in   1         strobe; request = cyc & stb
//   wb_we_i     in   1         1 = write, 0 = read
//   wb_sel_i    in   4         byte-lane enables, bit n -> dat[8n+7:8n]
//   wb_adr_i    in   32        byte address; word index = adr[ADDR_W+1:2]
//   wb_dat_i    in   32        write data
//   wb_dat_o    out  32        read data, valid while wb_ack_o = 1
//   wb_ack_o    out  1         single-cycle transfer acknowledge
//   wb_err_o    out  1         single-cycle error (address out of range)
//   clr_i       in   1         synchronous clear of word counter / full flag
//   wr_count_o  out  ADDR_W+1  acked non-empty writes, saturating at 2^ADDR_W
//   full_o      out  1         wr_count_o == 2^ADDR_W
// ---------------------------------------------------------------------------
module bram_log_slave #(
    parameter int ADDR_W = 11
) (
    input  logic              wb_clk_i,
    input  logic              reset_n,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    input  logic              clr_i,
    output logic [ADDR_W:0]   wr_count_o,
    output logic              full_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        ACK     = 2'd2,
        ERR     = 2'd3
    } state_t;

    state_t              state_reg;
    logic                cnt_pend_reg;   // current ACK belongs to a write with sel != 0
    logic [ADDR_W:0]     count_reg;

    logic                req;
    logic                in_range;
    logic                wr_en;
    logic                rd_en;
    logic [ADDR_W-1:0]   word_idx;
    logic [31:0]         rd_word;
    logic                unused_adr_bits;

    assign req       = wb_cyc_i & wb_stb_i;
    assign word_idx  = wb_adr_i[ADDR_W+1:2];
    assign in_range  = (wb_adr_i[31:ADDR_W+2] == '0);
    assign wr_en     = (state_reg == IDLE) && req && in_range && wb_we_i;
    assign rd_en     = (state_reg == IDLE) && req && in_range && !wb_we_i;

    // Byte offset within a word has no meaning on a 32-bit port.
    assign unused_adr_bits = ^wb_adr_i[1:0];

    // One byte-wide RAM per lane: each lane writes only when its select bit
    // is set, so partial writes leave the other bytes untouched. The read
    // port is registered (block RAM style), not reset.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [0:DEPTH-1];
            logic [7:0] rd_lane_reg;

            always_ff @(posedge wb_clk_i) begin
                if (wr_en && wb_sel_i[gi]) begin
                    lane_mem[word_idx] <= wb_dat_i[8*gi +: 8];
                end
                if (rd_en) begin
                    rd_lane_reg <= lane_mem[word_idx];
                end
            end

            assign rd_word[8*gi +: 8] = rd_lane_reg;
        end
    endgenerate

    // Transfer FSM. ack/err are registered and asserted only for the single
    // cycle spent in ACK/ERR, so they can never overlap or repeat.
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            wb_ack_o     <= 1'b0;
            wb_err_o     <= 1'b0;
            wb_dat_o     <= '0;
            cnt_pend_reg <= 1'b0;
        end else begin
            wb_ack_o     <= 1'b0;
            wb_err_o     <= 1'b0;
            cnt_pend_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        if (!in_range) begin
                            state_reg <= ERR;
                            wb_err_o  <= 1'b1;
                        end else if (wb_we_i) begin
                            // RAM lanes are written at this same edge.
                            state_reg    <= ACK;
                            wb_ack_o     <= 1'b1;
                            cnt_pend_reg <= |wb_sel_i;
                        end else begin
                            state_reg <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    // Master gave up the cycle: abandon the read silently.
                    if (!wb_cyc_i) begin
                        state_reg <= IDLE;
                    end else begin
                        wb_dat_o  <= rd_word;
                        wb_ack_o  <= 1'b1;
                        state_reg <= ACK;
                    end
                end
                ACK:     state_reg <= IDLE;
                ERR:     state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Word counter: bumps at the edge closing the ACK cycle of a non-empty
    // write; clear takes priority; saturates instead of wrapping.
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clr_i) begin
            count_reg <= '0;
        end else if ((state_reg == ACK) && cnt_pend_reg && (count_reg != FULL_CNT)) begin
            count_reg <= count_reg + {{ADDR_W{1'b0}}, 1'b1};
        end
    end

    assign wr_count_o = count_reg;
    assign full_o     = (count_reg == FULL_CNT);

endmodule

// File: tb/tb_bram_log_slave.sv
`timescale 1ns/1ps
module tb_bram_log_slave;

    localparam int ADDR_W = 11;
    localparam int DEPTH  = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, clr = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, dat_in = '0;
    logic [31:0] dat_out;
    logic        ack, err, full;
    logic [ADDR_W:0] count;

    always #6.667 clk = ~clk;

    bram_log_slave #(.ADDR_W(ADDR_W)) dut (
        .wb_clk_i   (clk),
        .reset_n    (reset_n),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_we_i    (we),
        .wb_sel_i   (sel),
        .wb_adr_i   (adr),
        .wb_dat_i   (dat_in),
        .wb_dat_o   (dat_out),
        .wb_ack_o   (ack),
        .wb_err_o   (err),
        .clr_i      (clr),
        .wr_count_o (count),
        .full_o     (full)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: word store with per-word "known" flag, and the count.
    logic [31:0] ref_mem   [0:DEPTH-1];
    bit          ref_valid [0:DEPTH-1];
    int          ref_cnt = 0;

    // Protocol monitor: ack/err exclusive and never two cycles running.
    logic prev_resp = 1'b0;
    always @(negedge clk) begin
        if (reset_n) begin
            check_eq("ack_err_exclusive", {63'd0, ack & err}, 64'd0);
            check_eq("resp_not_repeated", {63'd0, (ack | err) & prev_resp}, 64'd0);
        end
        prev_resp <= reset_n & (ack | err);
    end

    // Generic transfer. lat = edges from the request-sampling edge to the
    // response (0 if none within the bound). Optionally raises clr during ack.
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic clr_on_ack,
                           output logic got_ack, output logic got_err,
                           output logic [31:0] rdata, output int lat);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_in = d; sel = s;
        got_ack = 1'b0; got_err = 1'b0; rdata = '0; lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            if (ack || err) begin
                got_ack = ack; got_err = err; rdata = dat_out; lat = n;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (clr_on_ack && got_ack) clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        return (a >> (ADDR_W + 2)) == 0;
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic clr_on_ack);
        logic ga, ge; logic [31:0] rd; int lat; int w;
        bit ok;
        ok = addr_ok(a);
        wb_xfer(1'b1, a, d, s, clr_on_ack, ga, ge, rd, lat);
        w = int'((a >> 2) % DEPTH);
        if (ok) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
            if (s == 4'hF) ref_valid[w] = 1'b1;
            if (s != 4'h0 && ref_cnt < DEPTH) ref_cnt++;
            if (clr_on_ack) ref_cnt = 0;
        end
        $display("WR  adr=%08h dat=%08h sel=%h ack=%0b err=%0b lat=%0d cnt=%0d",
                 a, d, s, ga, ge, lat, count);
        check_eq("wr_latency", 64'(lat), 64'd1);
        check_eq("wr_ack", {63'd0, ga}, {63'd0, ok});
        check_eq("wr_err", {63'd0, ge}, {63'd0, !ok});
        check_eq("wr_count", 64'(count), 64'(ref_cnt));
        check_eq("wr_full", {63'd0, full}, {63'd0, ref_cnt == DEPTH});
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] rd);
        logic ga, ge; int lat; int w; bit ok;
        ok = addr_ok(a);
        w = int'((a >> 2) % DEPTH);
        wb_xfer(1'b0, a, 32'h0, 4'h0, 1'b0, ga, ge, rd, lat);
        $display("RD  adr=%08h dat=%08h ack=%0b err=%0b lat=%0d", a, rd, ga, ge, lat);
        check_eq("rd_latency", 64'(lat), ok ? 64'd2 : 64'd1);
        check_eq("rd_ack", {63'd0, ga}, {63'd0, ok});
        check_eq("rd_err", {63'd0, ge}, {63'd0, !ok});
        if (ok && ref_valid[w]) check_eq("rd_data", 64'(rd), 64'(ref_mem[w]));
        check_eq("rd_count", 64'(count), 64'(ref_cnt));
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] last0;
        for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = '0; ref_valid[i] = 1'b0; end

        // Power-up reset
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ack",   {63'd0, ack}, 64'd0);
        check_eq("rst_err",   {63'd0, err}, 64'd0);
        check_eq("rst_dat",   64'(dat_out), 64'd0);
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_full",  {63'd0, full}, 64'd0);
        reset_n = 1'b1;

        // Basic write / read
        do_write(32'h0000_0004, 32'hABCD_EF01, 4'hF, 1'b0);
        do_read (32'h0000_0004, rd);
        check_eq("basic_readback", 64'(rd), 64'hABCD_EF01);

        // Byte lanes and empty write
        do_write(32'h0000_0014, 32'hFFFF_FFFF, 4'hF, 1'b0);
        do_write(32'h0000_0014, 32'h1122_3344, 4'b0101, 1'b0);
        do_read (32'h0000_0014, rd);
        check_eq("partial_sel", 64'(rd), 64'hFF22_FF44);
        do_write(32'h0000_0014, 32'h5566_7788, 4'b0000, 1'b0);
        do_read (32'h0000_0014, rd);
        check_eq("sel0_unchanged", 64'(rd), 64'hFF22_FF44);

        // Out of range: aliases word 0 in the low bits, must not touch it
        do_write(32'h0000_0000, 32'h0BAD_F00D, 4'hF, 1'b0);
        do_write(32'h0000_2000, 32'hDEAD_BEEF, 4'hF, 1'b0);
        do_read (32'h0000_2000, rd);
        do_read (32'h0000_0000, rd);
        check_eq("oor_no_alias", 64'(rd), 64'h0BAD_F00D);

        // Reset while in RD_WAIT
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h4;
        @(posedge clk); #1;
        reset_n = 1'b0; cyc = 1'b0; stb = 1'b0;
        #1;
        check_eq("midrd_rst_ack",   {63'd0, ack}, 64'd0);
        check_eq("midrd_rst_err",   {63'd0, err}, 64'd0);
        check_eq("midrd_rst_dat",   64'(dat_out), 64'd0);
        check_eq("midrd_rst_count", 64'(count), 64'd0);
        ref_cnt = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_eq("post_rst_no_ack", {63'd0, ack | err}, 64'd0);
        end
        do_write(32'h0000_0008, 32'h1357_9BDF, 4'hF, 1'b0);

        // Abort a read in RD_WAIT, then an immediate write
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h8;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("abort_no_ack", {63'd0, ack | err}, 64'd0);
        end
        do_write(32'h0000_000C, 32'h2468_ACE0, 4'hF, 1'b0);
        do_read (32'h0000_0008, rd);

        // Saturation: clear, then DEPTH+1 full writes
        do_write(32'h0000_0010, 32'h0, 4'hF, 1'b1);
        for (int i = 0; i <= DEPTH; i++) begin
            logic [31:0] d;
            d = $urandom;
            if (i == DEPTH) last0 = d;
            do_write(32'((i % DEPTH) * 4), d, 4'hF, 1'b0);
            if (i == DEPTH - 2) check_eq("not_full_yet", {63'd0, full}, 64'd0);
        end
        check_eq("sat_count", 64'(count), 64'(DEPTH));
        check_eq("sat_full",  {63'd0, full}, 64'd1);
        do_read(32'h0, rd);
        check_eq("sat_word0_last", 64'(rd), 64'(last0));
        do_write(32'h0000_0020, 32'h7777_7777, 4'hF, 1'b1);
        check_eq("clr_count", 64'(count), 64'd0);
        check_eq("clr_full",  {63'd0, full}, 64'd0);

        // Randomized mix against the model
        for (int i = 0; i < 400; i++) begin
            int op;
            logic [31:0] a;
            op = int'($urandom_range(0, 11));
            a  = {19'd0, 11'($urandom_range(0, DEPTH - 1)), 2'($urandom)};
            if (op == 0) a[31 - int'($urandom_range(0, 18))] = 1'b1;
            if (op <= 1)      do_write(a, $urandom, 4'($urandom), 1'b0);
            else if (op <= 5) do_write(a, $urandom, 4'($urandom), 1'b0);
            else if (op == 6) do_write(a, $urandom, 4'hF, 1'b1);
            else              do_read(a, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
